// File: rtl/param_readback.sv
// Word-serial readback of the package/unit-scope parameter table, one 32-bit beat per handshake.
// Optional feature: define PARAM_READBACK_CHECKSUM_EN to append an XOR checksum beat.
module param_readback #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [3:0]        i_req_id,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_last,
  output logic              o_rsp_err,
  output logic              o_busy,
  output logic [1:0]        o_dbg_state
);

  // Handshake rule: a request transfers on a rising edge where i_req_valid && o_req_ready;
  // a beat transfers on a rising edge where o_rsp_valid && i_rsp_ready. The beat payload
  // is held unchanged while o_rsp_valid && !i_rsp_ready.

`ifdef PARAM_READBACK_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam logic [3:0]  ERR_ID      = 4'd15;
  localparam logic [31:0] ERR_WORD    = 32'hDEAD_BEEF;
  localparam logic [95:0] BIT600_LO   = 96'h000A364C_9849F829_8C66D659;
  localparam logic [7:0]  BYTE_P      = 8'd100;
  localparam logic [15:0] SHORTINT_P  = 16'hF618;  // 63000 truncated to 16 bits
  localparam logic [31:0] INT_P       = 32'd50;
  localparam logic [63:0] LONGINT_P   = 64'h0000011C_98C031CB;
  localparam logic [31:0] INTEGER_P   = 32'd125000;
  localparam logic [63:0] LOGIC130_LO = 64'h8C523EC7_DC553A2B;
  localparam logic [7:0]  REG8_P      = 8'd200;
  localparam logic [63:0] TIME_P      = 64'h00000002_540BE400;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_ERR    = 2'd2
  } state_t;

  function automatic logic [4:0] f_beats(input logic [3:0] id);
    case (id)
      4'd4:        f_beats = 5'd19;
      4'd8, 4'd12: f_beats = 5'd2;
      4'd10:       f_beats = 5'd5;
      default:     f_beats = 5'd1;
    endcase
  endfunction

  // Signed types are sign-extended to the beat; everything else zero-extends.
  function automatic logic [31:0] f_word(input logic [3:0] id, input logic [4:0] beat);
    logic b0;
    logic b1;
    b0 = (beat == 5'd0);
    b1 = (beat == 5'd1);
    f_word = 32'h0;
    case (id)
      4'd0:  if (b0) f_word = 32'd5;
      4'd1:  if (b0) f_word = 32'd8;
      4'd2:  if (b0) f_word = 32'd1;
      4'd3:  if (b0) f_word = 32'd3;
      4'd4: begin
        if (b0)                f_word = BIT600_LO[31:0];
        else if (b1)           f_word = BIT600_LO[63:32];
        else if (beat == 5'd2) f_word = BIT600_LO[95:64];
      end
      4'd5:  if (b0) f_word = {{24{BYTE_P[7]}}, BYTE_P};
      4'd6:  if (b0) f_word = {{16{SHORTINT_P[15]}}, SHORTINT_P};
      4'd7:  if (b0) f_word = INT_P;
      4'd8: begin
        if (b0)      f_word = LONGINT_P[31:0];
        else if (b1) f_word = LONGINT_P[63:32];
      end
      4'd9:  if (b0) f_word = INTEGER_P;
      4'd10: begin
        if (b0)      f_word = LOGIC130_LO[31:0];
        else if (b1) f_word = LOGIC130_LO[63:32];
      end
      4'd11: if (b0) f_word = {24'h0, REG8_P};
      4'd12: begin
        if (b0)      f_word = TIME_P[31:0];
        else if (b1) f_word = TIME_P[63:32];
      end
      4'd13: if (b0) f_word = 32'd11;
      4'd14: if (b0) f_word = 32'd4;
      default: f_word = 32'h0;
    endcase
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_id;
  logic [4:0]  r_beat_cnt;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_last;
  logic        r_rsp_err;
  logic [31:0] r_csum;

  logic        w_req_hs;
  logic        w_rsp_hs;
  logic [4:0]  w_beats;
  logic [4:0]  w_next_cnt;
  logic [31:0] w_next_word;
  logic [31:0] w_first_word;
  logic        w_first_last;

  assign w_req_hs     = (r_state == S_IDLE) && i_req_valid;
  assign w_rsp_hs     = r_rsp_valid && i_rsp_ready;
  assign w_beats      = f_beats(r_id);
  assign w_next_cnt   = r_beat_cnt + 5'd1;
  assign w_next_word  = f_word(r_id, w_next_cnt);
  assign w_first_word = f_word(i_req_id, 5'd0);
  assign w_first_last = !CSUM_EN && (f_beats(i_req_id) == 5'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // rsp_last marks the final beat in every mode, so it alone decides the return to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_req_hs) w_next_state = (i_req_id == ERR_ID) ? S_ERR : S_STREAM;
      S_STREAM: if (w_rsp_hs && r_rsp_last) w_next_state = S_IDLE;
      S_ERR:    if (w_rsp_hs) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id        <= 4'd0;
      r_beat_cnt  <= 5'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'h0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_csum      <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_hs) begin
            r_id        <= i_req_id;
            r_beat_cnt  <= 5'd0;
            r_rsp_valid <= 1'b1;
            if (i_req_id == ERR_ID) begin
              r_rsp_data <= ERR_WORD;
              r_rsp_last <= 1'b1;
              r_rsp_err  <= 1'b1;
              r_csum     <= 32'h0;
            end else begin
              r_rsp_data <= w_first_word;
              r_rsp_last <= w_first_last;
              r_rsp_err  <= 1'b0;
              r_csum     <= w_first_word;
            end
          end
        end
        S_STREAM: begin
          if (w_rsp_hs) begin
            if (r_rsp_last) begin
              r_rsp_valid <= 1'b0;
              r_rsp_data  <= 32'h0;
              r_rsp_last  <= 1'b0;
            end else if (w_next_cnt < w_beats) begin
              r_beat_cnt <= w_next_cnt;
              r_rsp_data <= w_next_word;
              r_rsp_last <= !CSUM_EN && (w_next_cnt == w_beats - 5'd1);
              r_csum     <= r_csum ^ w_next_word;
            end else begin
              // Data exhausted but not last: only reachable with the checksum beat enabled.
              r_beat_cnt <= w_next_cnt;
              r_rsp_data <= r_csum;
              r_rsp_last <= 1'b1;
            end
          end
        end
        S_ERR: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_last  <= 1'b0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_last  = r_rsp_last;
  assign o_rsp_err   = r_rsp_err;
  assign o_dbg_state = r_state;

endmodule

// File: doc/param_readback.md
# param_readback

Word-serial readback responder for the package-parameter test bench. It holds a constant table of every parameter from `cocotb_package_pkg_1`, `cocotb_package_pkg_2` and the compilation-unit scope. On a request by parameter ID, it streams the selected value out as 32-bit beats over a valid/ready channel. The block is the read end of those constants: cocotb drives the request side, then compares the streamed beats against values read through the simulator's package handles.

## Interface
- `DATA_W`, 32: response beat width; only 32 is supported.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request strobe.
- `req_ready` output 1: high only in IDLE.
- `req_id` input 4: parameter ID.
- `rsp_valid` output 1: beat valid.
- `rsp_ready` input 1: beat accept.
- `rsp_data` output 32: beat payload.
- `rsp_last` output 1: final beat of the response.
- `rsp_err` output 1: unknown ID; qualified by `rsp_valid`.
- `busy` output 1: high in any state other than IDLE.

## Operation
- **ID map** (ID: name, width, beats):
  - 0: five_int, 32, 1. 1: eight_logic, 32, 1. 2: bit_1_param, 1, 1. 3: bit_2_param, 2, 1.
  - 4: bit_600_param, 600, 19. 5: byte_param, 8, 1. 6: shortint_param, 16, 1. 7: int_param, 32, 1.
  - 8: longint_param, 64, 2. 9: integer_param, 32, 1. 10: logic_130_param, 130, 5. 11: reg_8_param, 8, 1.
  - 12: time_param, 64, 2. 13: eleven_int, 32, 1. 14: unit_four_int, 32, 1. 15: invalid.
- **Beat count**: ceil(width/32). Beats are sent least-significant word first.
- **Extension**: signed types (byte, shortint, int, longint, integer) are sign-extended to the beat boundary. All other types are zero-extended.
- **FSM states**: IDLE, STREAM, ERR.
  - IDLE -> STREAM on `req_valid && req_ready` with ID 0–14. The ID is latched and `beat_cnt` cleared.
  - IDLE -> ERR on the same handshake with ID 15.
  - STREAM: `rsp_data` = table word [id][beat_cnt]. `beat_cnt` increments on each `rsp_valid && rsp_ready`. The state returns to IDLE on the handshake of the last beat.
  - ERR: single beat, `rsp_data`=32'hDEADBEEF, `rsp_err`=1, `rsp_last`=1. Returns to IDLE on its handshake.
- While `busy`, `req_valid` is ignored and `req_id` changes have no effect.
- `rsp_data`, `rsp_last` and `rsp_err` stay stable while `rsp_valid && !rsp_ready`.

## Timing
- **Reset values**: `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_last`=0, `rsp_err`=0, `busy`=0, state IDLE, `beat_cnt`=0.
- **Reset mid-stream**: all outputs and state return to the reset values immediately (asynchronously). No partial response resumes after reset.
- **Latency**: request accepted in cycle T; beat 0 is valid in T+1; with `rsp_ready` held high, beat k is valid in T+1+k.
- **Back-to-back**: `req_ready` rises in the cycle after the last-beat handshake. Minimum request-to-request spacing is N+1 cycles, where N is the beat count.
- All response outputs are registered.

## Configuration
- **`PARAM_READBACK_CHECKSUM_EN` defined**: after the data beats, one extra beat is sent carrying the XOR of all data beats of that response.
  - `rsp_last` moves to this checksum beat.
  - ERR responses are unchanged (single beat).
- **`PARAM_READBACK_CHECKSUM_EN` not defined**: no checksum beat; `rsp_last` marks the final data beat.

## Test plan
- **Reset check**: reset asserted, then released → all outputs at their reset values. ID 0 with `rsp_ready`=1 → one beat 0x00000005, `rsp_last`=1, valid exactly 1 cycle after accept.
- **Sign extension**: ID 6 → 0xFFFFF618 (63000 truncated to 16 bits, sign-extended). ID 5 → 0x00000064. ID 2 → 0x00000001.
- **Multi-beat streams**:
  - ID 4 → 19 beats: 0x8C66D659, 0x9849F829, 0x000A364C, then sixteen beats of 0; `rsp_last` only on beat 18.
  - ID 12 → 0x540BE400, 0x00000002.
  - ID 8 → 0x98C031CB, 0x0000011C.
- **Backpressure**: ID 10 with `rsp_ready` toggled randomly → beats 0xDC553A2B, 0x8C523EC7, 0, 0, 0; data held stable while stalled; second request pulsed during the stream is ignored.
- **Error path**: ID 15 → single beat 0xDEADBEEF with `rsp_err`=1 and `rsp_last`=1. Then ID 14 → 0x00000004 and ID 13 → 0x0000000B at minimum spacing.
- **Reset mid-stream / checksum**:
  - `rst` pulsed during beat 7 of ID 4 → `rsp_valid`=0 immediately, `req_ready`=1 after release.
  - With `PARAM_READBACK_CHECKSUM_EN` defined: ID 12 gives a third beat 0x540BE402 with `rsp_last`=1.
